// File: rtl/lc3_wb_queue.sv
// LC-3 writeback queue: buffers register-file writes in order, retires one per cycle,
// tracks NZP condition codes and offers a pending-write check with youngest-entry bypass.
module lc3_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_dr,
    input  logic [15:0] req_data,
    input  logic        req_setcc,
    input  logic        rf_stall,
    output logic        wr_en,
    output logic [2:0]  write_reg,
    output logic [15:0] indata,
    output logic        cc_n,
    output logic        cc_z,
    output logic        cc_p,
    input  logic [2:0]  chk_reg,
    output logic        chk_hit,
    output logic [15:0] chk_data,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]    dr_q    [DEPTH];
    logic [2:0]    dr_d    [DEPTH];
    logic [15:0]   data_q  [DEPTH];
    logic [15:0]   data_d  [DEPTH];
    logic          setcc_q [DEPTH];
    logic          setcc_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [2:0]    cc_q, cc_d;
    logic          push;
    logic          retire;
    logic [AW-1:0] chk_idx;

    assign busy      = (count_q != '0);
    assign req_ready = (count_q != (AW+1)'(DEPTH));
    assign wr_en     = busy && !rf_stall;
    assign push      = req_valid && req_ready;
    assign retire    = wr_en;
    assign write_reg = busy ? dr_q[head_q] : 3'd0;
    assign indata    = busy ? data_q[head_q] : 16'd0;
    assign {cc_n, cc_z, cc_p} = cc_q;

    always_comb begin
        dr_d    = dr_q;
        data_d  = data_q;
        setcc_d = setcc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        cc_d    = cc_q;
        if (push) begin
            dr_d[tail_q]    = req_dr;
            data_d[tail_q]  = req_data;
            setcc_d[tail_q] = req_setcc;
            tail_d          = tail_q + 1'b1;
        end
        if (retire) begin
            head_d = head_q + 1'b1;
            if (setcc_q[head_q]) begin
                if (data_q[head_q][15])
                    cc_d = 3'b100;
                else if (data_q[head_q] == 16'd0)
                    cc_d = 3'b010;
                else
                    cc_d = 3'b001;
            end
        end
        case ({push, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last match found is the one nearest the tail.
    always_comb begin
        chk_hit  = 1'b0;
        chk_data = 16'd0;
        chk_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            chk_idx = head_q + AW'(i);
            if (((AW+1)'(i) < count_q) && (dr_q[chk_idx] == chk_reg)) begin
                chk_hit  = 1'b1;
                chk_data = data_q[chk_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dr_q[i]    <= 3'd0;
                data_q[i]  <= 16'd0;
                setcc_q[i] <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cc_q    <= 3'b010;
        end else begin
            dr_q    <= dr_d;
            data_q  <= data_d;
            setcc_q <= setcc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cc_q    <= cc_d;
        end
    end

endmodule

// File: doc/lc3_wb_queue.md
# lc3_wb_queue

Writeback queue for the LC-3 datapath: the writer side of the register file. It accepts register-write requests from execute/memory stages over a valid/ready handshake, buffers them in order, and drives the register file write port (`write_reg`, `indata`, `wr_en`) at one write per cycle. As each write retires it updates the NZP condition codes. It also exposes a pending-write check with data bypass, so decode can detect hazards on registers still queued.

## Interface

- `DEPTH`, default 4: queue entries; power of two, at least 2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  writeback request present.
- `req_ready`  out  1  queue can accept; equals not-full.
- `req_dr`  in  3  destination register R0–R7.
- `req_data`  in  16  value to write.
- `req_setcc`  in  1  the retiring write updates NZP.
- `rf_stall`  in  1  register file write port unavailable this cycle; no retire.
- `wr_en`  out  1  write strobe to the register file.
- `write_reg`  out  3  register file write index (queue head).
- `indata`  out  16  register file write data (queue head).
- `cc_n`, `cc_z`, `cc_p`  out  1 each  condition codes; exactly one is high at all times.
- `chk_reg`  in  3  register index to test for a pending write.
- `chk_hit`  out  1  some queued entry targets `chk_reg`.
- `chk_data`  out  16  data of the youngest queued entry targeting `chk_reg`.
- `busy`  out  1  queue non-empty.

## Operation

- Storage: circular buffer of DEPTH entries {dr, data, setcc}. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- Push: `req_valid && req_ready` at an edge writes the entry at tail, advances tail, and increments count.
- Retire: `wr_en = busy && !rf_stall`. At an edge with `wr_en` high, the register file captures the head, the head pointer advances, and count decrements.
- Push and retire on the same edge: both take effect and count is unchanged. This is legal at any count below DEPTH. When full, `req_ready` is 0, so no push occurs.
- `req_ready` depends only on count, never on `rf_stall` or `req_valid`.
- `write_reg` and `indata` show the head entry when busy and read 0 when empty.
- Condition codes: on a retire with setcc=1, the new value is taken from the retiring data:
  - data[15]=1 gives N.
  - data==0 gives Z.
  - otherwise P.
  - A retire with setcc=0 leaves the codes unchanged.
- Bypass:
  - `chk_hit`/`chk_data` are combinational from queue state and `chk_reg`.
  - The youngest match is the one closest to tail.
  - With no match, `chk_hit`=0 and `chk_data`=0.
  - The check ignores same-cycle incoming requests and does not account for a retire occurring at the coming edge.
- No state machine beyond the queue: the states are empty, partial, and full, as derived from count.

## Timing

- Reset (asynchronous, `rst_n`=0):
  - count=0, head=tail=0.
  - `wr_en`=0, `busy`=0, `req_ready`=1.
  - `write_reg`=0, `indata`=0.
  - cc = Z (`cc_z`=1).
  - `chk_hit`=0, `chk_data`=0.
- Reset mid-operation flushes all pending writes with no retire. Outputs take their reset values immediately, without waiting for a clock edge.
- Latency: a request accepted at edge k appears at the head no earlier than cycle k→k+1. It retires at edge k+1 if the queue was empty and `rf_stall`=0.
- Throughput: one push and one retire per cycle sustained.
- `rf_stall` held high freezes head, `wr_en`, and the codes. The queue fills and `req_ready` drops when count reaches DEPTH.
- Pointer wrap: entry order is preserved across the DEPTH-1 → 0 boundary.

## Test plan

- Reset then single request dr=3, data=16'h8001, setcc=1 → `wr_en` high for exactly one cycle with write_reg=3 and indata=16'h8001. `cc_n`=1 after that edge, and `busy`=0 afterward.
- `rf_stall`=1; push dr=1..4 with data 16'h0000, 16'h0005, 16'hFFFF, 16'h0002 (DEPTH=4) → `req_ready`=0 after the 4th push. Release the stall → four consecutive retires in order. cc sequence Z, P, N, P.
- Stall with entries {dr=2, 16'h0011} then {dr=2, 16'h0022} queued, chk_reg=2 → `chk_hit`=1, `chk_data`=16'h0022. With chk_reg=5 → `chk_hit`=0, `chk_data`=0.
- Continuous push every cycle with no stall for 10 requests → `wr_en` high every cycle after the first. Count never exceeds 1, pointers wrap, and no entry is lost or reordered.
- setcc=0 write of 16'h0000 after cc=P → cc stays P.
- Three entries queued under stall, then `rst_n` pulsed low mid-cycle → immediately `busy`=0, `wr_en`=0, and cc=Z. After reset release no writes occur.
